hilo_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit that owns and writes the HI/LO register pair; the
//  EX-stage operand-2 mux reads HI/LO for MFHI/MFLO. Executes MULT/MULTU/DIV/DIVU

---
 rtl/hilo_muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO writes.
// Mul/div takes WIDTH+2 edges from start to done; requests arriving while busy are dropped.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    iter;
    logic [WIDTH-1:0] acc_hi;   // multiply: product high half; divide: partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiply: multiplier / product low; divide: dividend / quotient
    logic [WIDTH-1:0] opb;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] rs_raw;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic             accept;
    logic             op_muldiv;
    logic             op_signed;
    logic             op_div;
    logic [WIDTH-1:0] rs_abs;
    logic [WIDTH-1:0] rt_abs;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy      = (state != IDLE);
    assign accept    = start && (state == IDLE);
    assign op_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign rs_abs    = (op_signed && rs[WIDTH-1]) ? (~rs + 1'b1) : rs;
    assign rt_abs    = (op_signed && rt[WIDTH-1]) ? (~rt + 1'b1) : rt;

    // One iteration of each algorithm, computed from the current accumulator pair
    assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : '0)};
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb};
    assign div_ok    = ~div_trial[WIDTH];

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
    assign quo_fix  = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    assign rem_fix  = neg_r ? (~acc_hi + 1'b1) : acc_hi;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && op_muldiv) state_next = RUN;
            RUN:     if (iter == LAST_ITER) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iter     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            rs_raw   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            done     <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done <= 1'b0;
            dz   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op_muldiv) begin
                            iter     <= '0;
                            acc_hi   <= '0;
                            acc_lo   <= op_div ? rs_abs : rt_abs;
                            opb      <= op_div ? rt_abs : rs_abs;
                            rs_raw   <= rs;
                            is_div   <= op_div;
                            neg_q    <= op_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                            neg_r    <= op_signed && rs[WIDTH-1];
                            div_zero <= op_div && (rt == '0);
                        end else if (op == OP_MTHI) begin
                            HI <= rs;
                        end else if (op == OP_MTLO) begin
                            LO <= rs;
                        end
                    end
                end
                RUN: begin
                    iter <= iter + CW'(1);
                    if (is_div) begin
                        acc_hi <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    dz   <= is_div && div_zero;
                    if (!is_div) begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        // Divide by zero reports the raw dividend and an all-ones quotient
                        HI <= rs_raw;
                        LO <= '1;
                    end else begin
                        HI <= rem_fix;
                        LO <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: arithmetic reference model compared every cycle, plus literal vectors.
module tb_hilo_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic: returns {dz, HI, LO}
    function automatic logic [64:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        model_result = '0;
        case (o)
            3'd1: begin p = 64'(sa * sb); model_result = {1'b0, p}; end
            3'd2: begin p = ua * ub;      model_result = {1'b0, p}; end
            3'd3, 3'd4: begin
                if (b == 32'h0) begin
                    model_result = {1'b1, a, 32'hFFFF_FFFF};
                end else if (o == 3'd3) begin
                    q = sa / sb;
                    r = sa % sb;
                    model_result = {1'b0, r[31:0], q[31:0]};
                end else begin
                    p = ua / ub;
                    model_result = {1'b0, 32'(ua % ub), p[31:0]};
                end
            end
            default: model_result = '0;
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic        m_done, m_dz;
    int          m_rem;
    logic [64:0] m_pend;

    // Timing model: result lands WIDTH+1 edges after the accepting edge
    always @(posedge clk) begin
        m_done <= 1'b0;
        m_dz   <= 1'b0;
        if (reset) begin
            m_hi  <= '0;
            m_lo  <= '0;
            m_rem <= 0;
        end else if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
                m_dz   <= m_pend[64];
                m_done <= 1'b1;
            end
        end else if (start) begin
            case (op)
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    m_pend <= model_result(op, rs, rt);
                    m_rem  <= 33;
                end
                3'd5: m_hi <= rs;
                3'd6: m_lo <= rs;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("cyc_hi",   {32'h0, HI}, {32'h0, m_hi});
            check("cyc_lo",   {32'h0, LO}, {32'h0, m_lo});
            check("cyc_busy", {63'h0, busy}, {63'h0, (m_rem != 0)});
            check("cyc_done", {63'h0, done}, {63'h0, m_done});
            check("cyc_dz",   {63'h0, dz},   {63'h0, m_dz});
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
    endtask

    task automatic wait_done(input string name, output int busy_cnt);
        bit seen;
        seen = 0;
        busy_cnt = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, {63'h0, seen}, 64'h1);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, output int busy_cnt);
        issue(o, a, b);
        wait_done(name, busy_cnt);
        check({name, "_hi"}, {32'h0, HI}, {32'h0, ehi});
        check({name, "_lo"}, {32'h0, LO}, {32'h0, elo});
        check({name, "_dz"}, {63'h0, dz}, {63'h0, edz});
        @(negedge clk);
        check({name, "_done_1cyc"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        int bc;
        int done_cnt;
        reset = 1'b1; start = 1'b0; op = 3'd0; rs = '0; rt = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checking = 1;
        @(negedge clk);
        check("rst_hi",   {32'h0, HI}, 64'h0);
        check("rst_lo",   {32'h0, LO}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);

        // Model sanity pins
        check("model_mult", 64'(model_result(3'd1, 32'hFFFF_FFFD, 32'd5)), 64'hFFFF_FFFF_FFFF_FFF1);
        check("model_div",  64'(model_result(3'd3, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, bc);
        check("mult_busy_cycles", 64'(bc), 64'd33);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, bc);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, bc);
        run_op("divu", 3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, bc);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, bc);
        run_op("divu_dz", 3'd4, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, bc);
        run_op("div_dz", 3'd3, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, bc);
        run_op("mult_mix", 3'd1, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FFFF, 32'hFFFF_D8F0, 1'b0, bc);

        // MTHI: single-edge write, no busy, no done
        issue(3'd5, 32'hAAAA_5555, 32'h0);
        @(negedge clk);
        check("mthi_hi",   {32'h0, HI}, 64'hAAAA_5555);
        check("mthi_busy", {63'h0, busy}, 64'h0);
        check("mthi_done", {63'h0, done}, 64'h0);

        // Requests while busy are dropped
        issue(3'd4, 32'd7, 32'd2);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; op = 3'd6; rs = 32'h1111_2222;
        @(posedge clk); #1 op = 3'd1; rs = 32'd9; rt = 32'd9;
        @(posedge clk); #1 start = 1'b0; op = 3'd0;
        wait_done("busy_drop", bc);
        check("busy_drop_hi", {32'h0, HI}, 64'd1);
        check("busy_drop_lo", {32'h0, LO}, 64'd3);
        repeat (3) @(negedge clk);
        check("busy_drop_idle", {63'h0, busy}, 64'h0);

        // Reset at iteration 10 of a divide
        issue(3'd3, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_hi",   {32'h0, HI}, 64'h0);
        check("abort_lo",   {32'h0, LO}, 64'h0);
        check("abort_busy", {63'h0, busy}, 64'h0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        run_op("mult_after", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, bc);

        // Reserved/none ops leave state untouched
        issue(3'd7, 32'hDEAD_BEEF, 32'd1);
        issue(3'd0, 32'hDEAD_BEEF, 32'd1);
        @(negedge clk);
        check("rsvd_lo",   {32'h0, LO}, 64'd6);
        check("rsvd_busy", {63'h0, busy}, 64'h0);

        repeat (2) @(negedge clk);
        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
